spi_bus_arbiter: RTL
====================

SPI_BUS_ARBITER -- requirements
Module: spi_bus_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- NUM_REQ, 3, number of requesters sharing one SPI master.
- DATA_WIDTH, 16, SPI word width.
- TIMEOUT_CYCLES, 4096, maximum clk cycles to wait for m_done.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, system clock.
- rst_n, in, 1, reset.
- enable, in, 1, block enable.
- req, in, NUM_REQ, level request per requester; held until its req_done.
- req_tx_data, in, NUM_REQ*DATA_WIDTH, word per requester; slice i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_rx_data, out, DATA_WIDTH, last received word, shared by all requesters.
- req_done, out, NUM_REQ, one-cycle completion pulse per requester.
- req_error, out, NUM_REQ, one-cycle timeout pulse per requester.
- grant_valid, out, 1, a transaction is owned.
- grant_idx, out, $clog2(NUM_REQ), current owner index.
- m_start, out, 1, start pulse to the SPI master.
- m_tx_data, out, DATA_WIDTH, word to the SPI master.
- m_rx_data, in, DATA_WIDTH, word from the SPI master.
- m_done, in, 1, SPI master transaction complete.
- m_cs_n, in, 1, chip select from the SPI master.
- cs_n_out, out, NUM_REQ, per-device chip selects, active low.

REQ-003 The block SHALL use one clock, clk; reset SHALL be rst_n, asynchronous and active-low.

Function
REQ-004 The FSM SHALL have four states: ARB_IDLE, ARB_START, ARB_WAIT, ARB_RELEASE.

REQ-005 ARB_IDLE with any req bit high SHALL, on the next edge:
- register grant_idx using round-robin order (search starts at rr_ptr),
- set grant_valid=1,
- latch the granted slice into m_tx_data,
- go to ARB_START.

REQ-006 rr_ptr SHALL reset to 0 and SHALL be set to (grant_idx+1) mod NUM_REQ in ARB_RELEASE.

REQ-007 ARB_START SHALL last exactly one cycle, with m_start=1 in that cycle only, then go to ARB_WAIT.

REQ-008 ARB_WAIT with m_done=1 SHALL, on the next edge:
- load req_rx_data from m_rx_data,
- pulse req_done[grant_idx] for one cycle,
- go to ARB_RELEASE.

REQ-009 In ARB_WAIT a timeout counter SHALL count cycles. If it reaches TIMEOUT_CYCLES without m_done, the block SHALL:
- pulse req_done[grant_idx] and req_error[grant_idx] together for one cycle,
- load req_rx_data with 0,
- go to ARB_RELEASE.

REQ-010 If m_done and the timeout occur in the same cycle, m_done SHALL win and req_error SHALL stay 0.

REQ-011 ARB_RELEASE SHALL last one cycle: clear grant_valid, update rr_ptr, go to ARB_IDLE. The minimum gap between two grants is therefore one idle cycle.

REQ-012 Chip select routing SHALL be combinational: cs_n_out[i] = m_cs_n when grant_valid=1 and grant_idx=i, else 1.

REQ-013 A req bit deasserted after grant SHALL be ignored. The transaction SHALL complete and req_done SHALL still pulse.

REQ-014 m_done seen in any state other than ARB_WAIT SHALL be ignored.

REQ-015 enable=0 SHALL, on the next edge:
- force ARB_IDLE,
- clear grant_valid, m_start, req_done, req_error and the timeout counter,
- hold rr_ptr, req_rx_data and m_tx_data.

An in-flight transaction is abandoned with no done pulse.

REQ-016 m_tx_data SHALL stay stable from grant until ARB_RELEASE.

Reset
REQ-017 On rst_n=0 the block SHALL asynchronously set:
- state=ARB_IDLE, rr_ptr=0, timeout counter=0,
- grant_valid=0, grant_idx=0,
- m_start=0, m_tx_data=0, req_rx_data=0,
- req_done=0, req_error=0.

Since grant_valid=0, cs_n_out SHALL read all ones.

REQ-018 Reset asserted mid-transaction SHALL give the same result as REQ-017, with no done or error pulse.

Verification
REQ-019 Single request: req=3'b010, slice1=16'h8032, m_done 20 cycles after m_start with m_rx_data=16'h00AB. Required:
- grant_idx=1 and m_tx_data=16'h8032,
- one m_start pulse,
- cs_n_out[1] follows m_cs_n; cs_n_out[0] and cs_n_out[2] stay 1,
- req_done=3'b010 for one cycle, req_rx_data=16'h00AB.

REQ-020 Fairness: req=3'b111 held continuously, with each transaction completing. Required: grant order 0,1,2,0; no requester is granted twice in a row.

REQ-021 Timeout: req=3'b001, m_done never asserted. Required: req_done[0] and req_error[0] pulse together exactly TIMEOUT_CYCLES cycles after entering ARB_WAIT; req_rx_data=0.

REQ-022 Collision: m_done asserted in the exact cycle the timeout is reached. Required: req_error stays 0 and req_rx_data=m_rx_data.

REQ-023 Abort: enable=0 during ARB_WAIT, then enable=1 with req=3'b100 and rr_ptr=2. Required:
- no done pulse for the aborted transaction,
- grant_valid=0 one cycle after enable fell,
- the new grant goes to requester 2.

REQ-024 Async reset mid-ARB_WAIT. Required: all outputs reach their REQ-017 values with no clk edge, and cs_n_out=3'b111.

Source files
------------

// File: rtl/spi_bus_arbiter_if.sv
// Bus bundle between the SPI bus arbiter (slave modport) and its requesters plus SPI master (master modport).
interface spi_bus_arbiter_if #(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = 16
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Handshake: req[i] is a level held until req_done[i] pulses; the SPI leg is a
    // one-cycle m_start pulse answered later by a one-cycle m_done pulse with m_rx_data valid.
    logic                           enable;
    logic [NUM_REQ-1:0]             req;
    logic [NUM_REQ*DATA_WIDTH-1:0]  req_tx_data;
    logic [DATA_WIDTH-1:0]          req_rx_data;
    logic [NUM_REQ-1:0]             req_done;
    logic [NUM_REQ-1:0]             req_error;
    logic                           grant_valid;
    logic [IDX_W-1:0]               grant_idx;
    logic                           m_start;
    logic [DATA_WIDTH-1:0]          m_tx_data;
    logic [DATA_WIDTH-1:0]          m_rx_data;
    logic                           m_done;
    logic                           m_cs_n;
    logic [NUM_REQ-1:0]             cs_n_out;

    modport slave (
        input  enable, req, req_tx_data, m_rx_data, m_done, m_cs_n,
        output req_rx_data, req_done, req_error, grant_valid, grant_idx,
               m_start, m_tx_data, cs_n_out
    );

    modport master (
        output enable, req, req_tx_data, m_rx_data, m_done, m_cs_n,
        input  req_rx_data, req_done, req_error, grant_valid, grant_idx,
               m_start, m_tx_data, cs_n_out
    );
endinterface

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one SPI master among NUM_REQ requesters, with a
// per-transaction m_done timeout and combinational chip-select routing.
module spi_bus_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_bus_arbiter_if.slave bus,
    output logic [1:0]       state_dbg
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_START   = 2'd1,
        ARB_WAIT    = 2'd2,
        ARB_RELEASE = 2'd3
    } arb_state_e;

    arb_state_e            state, state_nxt;
    logic [IDX_W-1:0]      rr_ptr, grant_idx, pick_idx, rr_next;
    logic                  pick_found, done_hit, timeout_hit, grant_valid;
    logic [CNT_W-1:0]      wait_cnt;
    logic [DATA_WIDTH-1:0] m_tx_data, req_rx_data;
    logic [NUM_REQ-1:0]    req_done, req_error, grant_oh, cs_n_out;

    // Descending scan so the requester closest at-or-after rr_ptr is the last assignment.
    always_comb begin
        pick_idx   = rr_ptr;
        pick_found = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req[(int'(rr_ptr) + k) % NUM_REQ]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign grant_oh    = NUM_REQ'(1) << grant_idx;
    assign rr_next     = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    assign done_hit    = (state == ARB_WAIT) && bus.m_done;
    // m_done takes priority over a timeout landing in the same cycle.
    assign timeout_hit = (state == ARB_WAIT) && !bus.m_done &&
                         (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ARB_IDLE;
            rr_ptr      <= '0;
            wait_cnt    <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            m_tx_data   <= '0;
            req_rx_data <= '0;
            req_done    <= '0;
            req_error   <= '0;
        end else begin
            state     <= state_nxt;
            req_done  <= '0;
            req_error <= '0;
            if (!bus.enable) begin
                grant_valid <= 1'b0;
                wait_cnt    <= '0;
            end else begin
                case (state)
                    ARB_IDLE: if (pick_found) begin
                        grant_idx   <= pick_idx;
                        grant_valid <= 1'b1;
                        m_tx_data   <= bus.req_tx_data[pick_idx*DATA_WIDTH +: DATA_WIDTH];
                    end
                    ARB_START: wait_cnt <= '0;
                    ARB_WAIT: begin
                        if (done_hit) begin
                            req_rx_data <= bus.m_rx_data;
                            req_done    <= grant_oh;
                        end else if (timeout_hit) begin
                            req_rx_data <= '0;
                            req_done    <= grant_oh;
                            req_error   <= grant_oh;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                    ARB_RELEASE: begin
                        grant_valid <= 1'b0;
                        rr_ptr      <= rr_next;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE:    if (pick_found) state_nxt = ARB_START;
            ARB_START:   state_nxt = ARB_WAIT;
            ARB_WAIT:    if (done_hit || timeout_hit) state_nxt = ARB_RELEASE;
            ARB_RELEASE: state_nxt = ARB_IDLE;
            default:     state_nxt = ARB_IDLE;
        endcase
        if (!bus.enable) state_nxt = ARB_IDLE;
    end

    always_comb begin
        state_dbg = state;
        cs_n_out  = '1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_valid && (grant_idx == IDX_W'(i))) cs_n_out[i] = bus.m_cs_n;
        end
    end

    assign bus.m_start     = (state == ARB_START);
    assign bus.grant_valid = grant_valid;
    assign bus.grant_idx   = grant_idx;
    assign bus.m_tx_data   = m_tx_data;
    assign bus.req_rx_data = req_rx_data;
    assign bus.req_done    = req_done;
    assign bus.req_error   = req_error;
    assign bus.cs_n_out    = cs_n_out;
endmodule
